// File: rtl/status_stack.sv
// status_stack: mstatus/sstatus interrupt-enable and previous-privilege stack.
// Pushes IE/privilege on traps, pops on mret/sret, and applies WARL-legalized
// CSR writes. All fields are registered and commit only when StallW is low.
module status_stack #(
    parameter int unsigned XLEN        = 64,
    parameter bit          S_SUPPORTED = 1'b1,
    parameter bit          U_SUPPORTED = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallW,
    input  logic            TrapM,
    input  logic            DelegateM,
    input  logic            mretM,
    input  logic            sretM,
    input  logic [1:0]      PrivilegeModeW,
    input  logic            WriteMSTATUSM,
    input  logic            WriteSSTATUSM,
    input  logic [XLEN-1:0] CSRWriteValM,
    output logic            STATUS_MIE,
    output logic            STATUS_SIE,
    output logic            STATUS_MPIE,
    output logic            STATUS_SPIE,
    output logic [1:0]      STATUS_MPP,
    output logic            STATUS_SPP,
    output logic            STATUS_MPRV,
    output logic [XLEN-1:0] MSTATUS_REGW,
    output logic [XLEN-1:0] SSTATUS_REGW
);

    localparam int unsigned SIE_BIT  = 1;
    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned SPIE_BIT = 5;
    localparam int unsigned MPIE_BIT = 7;
    localparam int unsigned SPP_BIT  = 8;
    localparam int unsigned MPP_LO   = 11;
    localparam int unsigned MPRV_BIT = 17;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    logic       mie_q,  mie_d;
    logic       sie_q,  sie_d;
    logic       mpie_q, mpie_d;
    logic       spie_q, spie_d;
    logic       spp_q,  spp_d;
    logic [1:0] mpp_q,  mpp_d;
    logic       mprv_q, mprv_d;

    logic       trap_to_s_c;
    logic [1:0] mpp_req_c;
    logic       mpp_req_ok_c;
    logic [XLEN-1:0] mstatus_c;
    logic [XLEN-1:0] sstatus_c;

    // Write-data bits that map to no implemented field.
    logic unused_wdata_c;
    assign unused_wdata_c = ^{CSRWriteValM[XLEN-1:MPRV_BIT+1],
                              CSRWriteValM[MPRV_BIT-1:MPP_LO+2],
                              CSRWriteValM[MPP_LO-1:SPP_BIT+1],
                              CSRWriteValM[6], CSRWriteValM[4],
                              CSRWriteValM[2], CSRWriteValM[0]};

    assign trap_to_s_c = S_SUPPORTED & DelegateM;
    assign mpp_req_c   = CSRWriteValM[MPP_LO+1:MPP_LO];

    // WARL check on a CSR-written MPP: reserved or unimplemented modes are dropped.
    always_comb begin
        mpp_req_ok_c = 1'b1;
        if (mpp_req_c == 2'b10)                        mpp_req_ok_c = 1'b0;
        if ((mpp_req_c == PRIV_S) && !S_SUPPORTED)     mpp_req_ok_c = 1'b0;
        if ((mpp_req_c == PRIV_U) && !U_SUPPORTED)     mpp_req_ok_c = 1'b0;
    end

    // Next-state: one prioritized event per unstalled cycle, then WARL constants.
    always_comb begin
        mie_d  = mie_q;
        sie_d  = sie_q;
        mpie_d = mpie_q;
        spie_d = spie_q;
        spp_d  = spp_q;
        mpp_d  = mpp_q;
        mprv_d = mprv_q;
        if (!StallW) begin
            if (TrapM) begin
                if (trap_to_s_c) begin
                    spie_d = sie_q;
                    sie_d  = 1'b0;
                    spp_d  = PrivilegeModeW[0];
                end else begin
                    mpie_d = mie_q;
                    mie_d  = 1'b0;
                    mpp_d  = PrivilegeModeW;
                end
            end else if (mretM) begin
                mie_d  = mpie_q;
                mpie_d = 1'b1;
                mpp_d  = U_SUPPORTED ? PRIV_U : PRIV_M;
                if (mpp_q != PRIV_M) mprv_d = 1'b0;
            end else if (sretM && S_SUPPORTED) begin
                sie_d  = spie_q;
                spie_d = 1'b1;
                spp_d  = 1'b0;
                mprv_d = 1'b0;
            end else if (WriteMSTATUSM) begin
                mie_d  = CSRWriteValM[MIE_BIT];
                sie_d  = CSRWriteValM[SIE_BIT];
                mpie_d = CSRWriteValM[MPIE_BIT];
                spie_d = CSRWriteValM[SPIE_BIT];
                spp_d  = CSRWriteValM[SPP_BIT];
                mprv_d = CSRWriteValM[MPRV_BIT];
                if (mpp_req_ok_c) mpp_d = mpp_req_c;
            end else if (WriteSSTATUSM) begin
                sie_d  = CSRWriteValM[SIE_BIT];
                spie_d = CSRWriteValM[SPIE_BIT];
                spp_d  = CSRWriteValM[SPP_BIT];
            end
        end
        if (!S_SUPPORTED) begin
            sie_d  = 1'b0;
            spie_d = 1'b0;
            spp_d  = 1'b0;
        end
        if (!U_SUPPORTED) begin
            mprv_d = 1'b0;
            mpp_d  = PRIV_M;
        end
    end

    // Field registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mie_q  <= 1'b0;
            sie_q  <= 1'b0;
            mpie_q <= 1'b0;
            spie_q <= 1'b0;
            spp_q  <= 1'b0;
            mpp_q  <= PRIV_M;
            mprv_q <= 1'b0;
        end else begin
            mie_q  <= mie_d;
            sie_q  <= sie_d;
            mpie_q <= mpie_d;
            spie_q <= spie_d;
            spp_q  <= spp_d;
            mpp_q  <= mpp_d;
            mprv_q <= mprv_d;
        end
    end

    // Readback images built from the registered fields.
    always_comb begin
        mstatus_c                     = '0;
        mstatus_c[SIE_BIT]            = sie_q;
        mstatus_c[MIE_BIT]            = mie_q;
        mstatus_c[SPIE_BIT]           = spie_q;
        mstatus_c[MPIE_BIT]           = mpie_q;
        mstatus_c[SPP_BIT]            = spp_q;
        mstatus_c[MPP_LO+1:MPP_LO]    = mpp_q;
        mstatus_c[MPRV_BIT]           = mprv_q;
        sstatus_c                     = '0;
        sstatus_c[SIE_BIT]            = sie_q;
        sstatus_c[SPIE_BIT]           = spie_q;
        sstatus_c[SPP_BIT]            = spp_q;
    end

    assign STATUS_MIE   = mie_q;
    assign STATUS_SIE   = sie_q;
    assign STATUS_MPIE  = mpie_q;
    assign STATUS_SPIE  = spie_q;
    assign STATUS_MPP   = mpp_q;
    assign STATUS_SPP   = spp_q;
    assign STATUS_MPRV  = mprv_q;
    assign MSTATUS_REGW = mstatus_c;
    assign SSTATUS_REGW = sstatus_c;

endmodule

// File: tb/tb_status_stack.sv
// Bench for status_stack: directed walk of the privileged trap/return flows,
// then random events, checked against a word-level model of mstatus.
module tb_status_stack;

    localparam logic [63:0] MMASK = 64'h0000_0000_0002_19AA;
    localparam logic [63:0] SMASK = 64'h0000_0000_0000_0122;

    logic        clk = 1'b0;
    logic        reset, StallW, TrapM, DelegateM, mretM, sretM;
    logic        WriteMSTATUSM, WriteSSTATUSM;
    logic [1:0]  PrivilegeModeW;
    logic [63:0] CSRWriteValM;

    logic        a_mie, a_sie, a_mpie, a_spie, a_spp, a_mprv;
    logic [1:0]  a_mpp;
    logic [63:0] a_mst, a_sst;
    logic        b_mie, b_sie, b_mpie, b_spie, b_spp, b_mprv;
    logic [1:0]  b_mpp;
    logic [63:0] b_mst, b_sst;

    logic [63:0] m_a, m_b;
    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    status_stack #(.XLEN(64), .S_SUPPORTED(1'b1), .U_SUPPORTED(1'b1)) u_full (
        .clk(clk), .reset(reset), .StallW(StallW), .TrapM(TrapM), .DelegateM(DelegateM),
        .mretM(mretM), .sretM(sretM), .PrivilegeModeW(PrivilegeModeW),
        .WriteMSTATUSM(WriteMSTATUSM), .WriteSSTATUSM(WriteSSTATUSM), .CSRWriteValM(CSRWriteValM),
        .STATUS_MIE(a_mie), .STATUS_SIE(a_sie), .STATUS_MPIE(a_mpie), .STATUS_SPIE(a_spie),
        .STATUS_MPP(a_mpp), .STATUS_SPP(a_spp), .STATUS_MPRV(a_mprv),
        .MSTATUS_REGW(a_mst), .SSTATUS_REGW(a_sst));

    status_stack #(.XLEN(64), .S_SUPPORTED(1'b0), .U_SUPPORTED(1'b1)) u_nos (
        .clk(clk), .reset(reset), .StallW(StallW), .TrapM(TrapM), .DelegateM(DelegateM),
        .mretM(mretM), .sretM(sretM), .PrivilegeModeW(PrivilegeModeW),
        .WriteMSTATUSM(WriteMSTATUSM), .WriteSSTATUSM(WriteSSTATUSM), .CSRWriteValM(CSRWriteValM),
        .STATUS_MIE(b_mie), .STATUS_SIE(b_sie), .STATUS_MPIE(b_mpie), .STATUS_SPIE(b_spie),
        .STATUS_MPP(b_mpp), .STATUS_SPP(b_spp), .STATUS_MPRV(b_mprv),
        .MSTATUS_REGW(b_mst), .SSTATUS_REGW(b_sst));

    // Reference: next mstatus word from the current word and this cycle's inputs.
    function automatic logic [63:0] ref_next(input logic [63:0] m, input bit s_on, input bit u_on);
        logic [63:0] n;
        logic [1:0]  req;
        if (reset)  return 64'h1800;
        if (StallW) return m;
        n = m;
        if (TrapM) begin
            if (s_on && DelegateM) begin
                n[5] = m[1]; n[1] = 1'b0; n[8] = PrivilegeModeW[0];
            end else begin
                n[7] = m[3]; n[3] = 1'b0; n[12:11] = PrivilegeModeW;
            end
        end else if (mretM) begin
            n[3] = m[7]; n[7] = 1'b1;
            if (m[12:11] != 2'b11) n[17] = 1'b0;
            n[12:11] = u_on ? 2'b00 : 2'b11;
        end else if (sretM && s_on) begin
            n[1] = m[5]; n[5] = 1'b1; n[8] = 1'b0; n[17] = 1'b0;
        end else if (WriteMSTATUSM) begin
            n   = (m & ~MMASK) | (CSRWriteValM & MMASK);
            req = CSRWriteValM[12:11];
            if (req == 2'b10 || (req == 2'b01 && !s_on) || (req == 2'b00 && !u_on))
                n[12:11] = m[12:11];
        end else if (WriteSSTATUSM) begin
            n = (m & ~SMASK) | (CSRWriteValM & SMASK);
        end
        if (!s_on) n = n & ~SMASK;
        if (!u_on) begin n[17] = 1'b0; n[12:11] = 2'b11; end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ":A.mstatus"}, a_mst, m_a);
        chk({tag, ":A.sstatus"}, a_sst, m_a & SMASK);
        chk({tag, ":A.fields"}, 64'({a_mie, a_sie, a_mpie, a_spie, a_spp, a_mpp, a_mprv}),
            64'({m_a[3], m_a[1], m_a[7], m_a[5], m_a[8], m_a[12:11], m_a[17]}));
        chk({tag, ":B.mstatus"}, b_mst, m_b);
        chk({tag, ":B.sstatus"}, b_sst, m_b & SMASK);
        chk({tag, ":B.fields"}, 64'({b_mie, b_sie, b_mpie, b_spie, b_spp, b_mpp, b_mprv}),
            64'({m_b[3], m_b[1], m_b[7], m_b[5], m_b[8], m_b[12:11], m_b[17]}));
    endtask

    task automatic idle();
        reset = 1'b0; StallW = 1'b0; TrapM = 1'b0; DelegateM = 1'b0;
        mretM = 1'b0; sretM = 1'b0; WriteMSTATUSM = 1'b0; WriteSSTATUSM = 1'b0;
        PrivilegeModeW = 2'b00; CSRWriteValM = '0;
    endtask

    // One clock: models advance with the inputs present at the edge, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        m_a = ref_next(m_a, 1'b1, 1'b1);
        m_b = ref_next(m_b, 1'b0, 1'b1);
        #1;
        chk_all(tag);
        idle();
    endtask

    initial begin
        idle();
        m_a = '0;
        m_b = '0;

        reset = 1'b1;
        tick("reset");
        chk("reset_mstatus", a_mst, 64'h1800);
        chk("reset_sstatus", b_sst, 64'h0);
        chk("reset_mpp", 64'(a_mpp), 64'h3);

        // Trap to M from U and return.
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h8;
        tick("wr_mie");
        TrapM = 1'b1; PrivilegeModeW = 2'b00;
        tick("trap_m");
        chk("trap_m_fields", 64'({a_mie, a_mpie, a_mpp}), 64'b0_1_00);
        mretM = 1'b1;
        tick("mret");
        chk("mret_fields", 64'({a_mie, a_mpie, a_mpp}), 64'b1_1_00);

        // Delegated trap to S and return.
        WriteSSTATUSM = 1'b1; CSRWriteValM = 64'h2;
        tick("wr_sie");
        TrapM = 1'b1; DelegateM = 1'b1; PrivilegeModeW = 2'b00;
        tick("trap_s");
        chk("trap_s_fields", 64'({a_sie, a_spie, a_spp}), 64'b0_1_0);
        sretM = 1'b1;
        tick("sret");
        chk("sret_fields", 64'({a_sie, a_spie, a_spp, a_mprv}), 64'b1_1_0_0);

        // MPP WARL and MPRV clear on mret to a lower mode.
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h1800;
        tick("wr_mpp11");
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h1000;
        tick("wr_mpp10");
        chk("mpp10_kept", 64'(a_mpp), 64'h3);
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h0;
        #1;
        chk("same_cycle_read", a_mst, m_a);
        tick("wr_mpp00");
        chk("mpp00", 64'(a_mpp), 64'h0);
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h20000;
        tick("wr_mprv");
        chk("mprv_set", 64'(a_mprv), 64'h1);
        mretM = 1'b1;
        tick("mret_mprv");
        chk("mprv_clr", 64'(a_mprv), 64'h0);

        // Stall holds everything; trap beats mret.
        StallW = 1'b1; TrapM = 1'b1; WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h1FFFFF;
        PrivilegeModeW = 2'b01;
        tick("stall");
        TrapM = 1'b1; mretM = 1'b1; PrivilegeModeW = 2'b01;
        tick("trap_vs_mret");
        chk("trap_vs_mret_mpp", 64'(a_mpp), 64'h1);

        // No-S instance: S fields stay 0, delegated trap goes to M.
        WriteMSTATUSM = 1'b1; CSRWriteValM = 64'h1FFFFF;
        tick("nos_wr");
        chk("nos_sfields", 64'({b_sie, b_spie, b_spp, b_mpp}), 64'b0_0_0_11);
        TrapM = 1'b1; DelegateM = 1'b1; PrivilegeModeW = 2'b00;
        tick("nos_trap");
        chk("nos_trap_fields", 64'({b_mie, b_mpie, b_mpp}), 64'b0_1_00);

        // Random event mix.
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 31) == 0);
            StallW        = ($urandom_range(0, 3) == 0);
            TrapM         = ($urandom_range(0, 5) == 0);
            DelegateM     = 1'($urandom);
            mretM         = ($urandom_range(0, 5) == 0);
            sretM         = ($urandom_range(0, 5) == 0);
            WriteMSTATUSM = ($urandom_range(0, 3) == 0);
            WriteSSTATUSM = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       PrivilegeModeW = 2'b00;
                1:       PrivilegeModeW = 2'b01;
                default: PrivilegeModeW = 2'b11;
            endcase
            CSRWriteValM = {$urandom, $urandom};
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
